// File: rtl/fuzz_harness_pkg.sv
// Shared constants, state encoding and LFSR step for the vector fuzz harness.
package fuzz_harness_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fuzz_state_e;

    localparam logic [31:0] LFSR_POLY     = 32'h80200003;
    localparam logic [31:0] MISR_POLY     = 32'h04C11DB7;
    localparam logic [31:0] MIX_K         = 32'h9E3779B9;
    localparam logic [31:0] ZERO_SEED_SUB = 32'h00000001;

    // Galois right-shift LFSR step.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        lfsr_step = s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/fuzz_misr.sv
// 32-bit MISR compacting an OUT_W-bit response; the response is XOR-folded
// into 32-bit chunks starting at bit 0, the top chunk zero-extended.
module fuzz_misr
    import fuzz_harness_pkg::*;
#(
    parameter int OUT_W = 87
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [OUT_W-1:0] resp_i,
    output logic [31:0]      sig_o
);

    logic [31:0] fold;
    logic [31:0] sig_q;
    logic [31:0] sig_d;

    // Fold the response down to one 32-bit word; bits past OUT_W stay zero.
    always_comb begin
        fold = '0;
        for (int b = 0; b < OUT_W; b++) begin
            fold[b % 32] = fold[b % 32] ^ resp_i[b];
        end
    end

    // Shift with polynomial feedback, then mix in the folded response.
    always_comb begin
        sig_d = (sig_q << 1) ^ (sig_q[31] ? MISR_POLY : 32'h0) ^ fold;
    end

    // Signature register: cleared on reset or run start, updated when enabled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sig_q <= '0;
        end else if (clr_i) begin
            sig_q <= '0;
        end else if (en_i) begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/fuzz_vec_harness.sv
// Pseudo-random stimulus generator with MISR response compaction.
//   state | meaning
//   IDLE  | waiting for start; signature and vec_cnt hold last run's values
//   RUN   | one vector per cycle until num_vec issued
//   DRAIN | LAT cycles letting the last responses reach the MISR
//   DONE  | single-cycle done pulse, then back to IDLE
module fuzz_vec_harness
    import fuzz_harness_pkg::*;
#(
    parameter int IN_W  = 74,
    parameter int OUT_W = 87,
    parameter int LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      seed,
    input  logic [15:0]      num_vec,
    output logic [IN_W-1:0]  stim,
    output logic             stim_valid,
    input  logic [OUT_W-1:0] resp,
    output logic             busy,
    output logic             done,
    output logic [31:0]      signature,
    output logic [15:0]      vec_cnt
);

    localparam logic [2:0] DRAIN_LOAD = 3'(LAT - 1);

    fuzz_state_e     state_q;
    logic [31:0]     lfsr_q;
    logic [31:0]     lfsr_d;
    logic [15:0]     vec_cnt_q;
    logic [15:0]     vec_cnt_d;
    logic [15:0]     num_q;
    logic [2:0]      drain_q;
    logic            stim_valid_q;
    logic            busy_q;
    logic            done_q;
    logic [LAT-1:0]  vld_q;
    logic [IN_W-1:0] stim_mix;
    logic            run_start;

    assign lfsr_d    = lfsr_step(lfsr_q);
    assign vec_cnt_d = vec_cnt_q + 16'd1;
    assign run_start = (state_q == ST_IDLE) && start;

    // Expand the LFSR word into IN_W bits: copy k is lfsr ^ (k * MIX_K).
    always_comb begin
        logic [31:0] chunk;
        chunk    = '0;
        stim_mix = '0;
        for (int b = 0; b < IN_W; b++) begin
            chunk       = lfsr_q ^ (32'(b / 32) * MIX_K);
            stim_mix[b] = chunk[b % 32];
        end
    end

    // Sequencer FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            lfsr_q       <= '0;
            vec_cnt_q    <= '0;
            num_q        <= '0;
            drain_q      <= '0;
            stim_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        lfsr_q    <= (seed == '0) ? ZERO_SEED_SUB : seed;
                        vec_cnt_q <= '0;
                        num_q     <= num_vec;
                        if (num_vec == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q      <= ST_RUN;
                            stim_valid_q <= 1'b1;
                            busy_q       <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    lfsr_q    <= lfsr_d;
                    vec_cnt_q <= vec_cnt_d;
                    if (vec_cnt_d == num_q) begin
                        state_q      <= ST_DRAIN;
                        stim_valid_q <= 1'b0;
                        drain_q      <= DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == 3'd0) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q - 3'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Delay line marking which cycles carry a response to a live vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= stim_valid_q;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    fuzz_misr #(
        .OUT_W (OUT_W)
    ) u_misr (
        .clk_i  (clk),
        .rst_i  (rst),
        .clr_i  (run_start),
        .en_i   (vld_q[LAT-1]),
        .resp_i (resp),
        .sig_o  (signature)
    );

    assign stim       = stim_valid_q ? stim_mix : '0;
    assign stim_valid = stim_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign vec_cnt    = vec_cnt_q;

endmodule

// File: tb/tb_fuzz_vec_harness.sv
// Directed checks of the fuzz harness: a narrow LAT=1 instance and a
// default-width LAT=3 instance sharing one clock and reset.
module tb_fuzz_vec_harness;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start_a = 1'b0;
    logic [31:0] seed_a  = '0;
    logic [15:0] num_a   = '0;
    logic [31:0] stim_a;
    logic        sv_a;
    logic [31:0] resp_a  = '0;
    logic        busy_a, done_a;
    logic [31:0] sig_a;
    logic [15:0] vc_a;

    logic        start_b = 1'b0;
    logic [31:0] seed_b  = '0;
    logic [15:0] num_b   = '0;
    logic [73:0] stim_b;
    logic        sv_b;
    logic [86:0] resp_b  = '0;
    logic        busy_b, done_b;
    logic [31:0] sig_b;
    logic [15:0] vc_b;

    int n_assert = 0;
    int n_fail   = 0;
    int busy_cnt;
    int done_cnt;
    int sv_cnt;
    logic got_done;

    always #5 clk = ~clk;

    fuzz_vec_harness #(.IN_W(32), .OUT_W(32), .LAT(1)) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .start      (start_a),
        .seed       (seed_a),
        .num_vec    (num_a),
        .stim       (stim_a),
        .stim_valid (sv_a),
        .resp       (resp_a),
        .busy       (busy_a),
        .done       (done_a),
        .signature  (sig_a),
        .vec_cnt    (vc_a)
    );

    fuzz_vec_harness #(.IN_W(74), .OUT_W(87), .LAT(3)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .start      (start_b),
        .seed       (seed_b),
        .num_vec    (num_b),
        .stim       (stim_b),
        .stim_valid (sv_b),
        .resp       (resp_b),
        .busy       (busy_b),
        .done       (done_b),
        .signature  (sig_b),
        .vec_cnt    (vc_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset
        step(); step();
        chk("rst_stim_a",  stim_a, 0);
        chk("rst_sv_a",    sv_a,   0);
        chk("rst_busy_a",  busy_a, 0);
        chk("rst_done_a",  done_a, 0);
        chk("rst_sig_a",   sig_a,  0);
        chk("rst_vc_a",    vc_a,   0);
        chk("rst_stim_b",  stim_b, 0);
        rst = 1'b0;
        step();

        // zero seed substitutes 1; two vectors, resp=1 gives signature 3
        seed_a = 32'h0; num_a = 16'd2; resp_a = 32'h1; start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("v0_stim_a",  stim_a, 32'h00000001);
        chk("v0_sv_a",    sv_a,   1);
        chk("v0_busy_a",  busy_a, 1);
        step();
        chk("v1_stim_a",  stim_a, 32'h80200003);
        chk("v1_vc_a",    vc_a,   1);
        step();
        chk("drain_sv_a",   sv_a,   0);
        chk("drain_stim_a", stim_a, 0);
        chk("drain_vc_a",   vc_a,   2);
        step();
        chk("n2_done_a", done_a, 1);
        chk("n2_sig_a",  sig_a,  32'h00000003);
        step();
        step();
        chk("n2_hold_done_a", done_a, 0);
        chk("n2_hold_sig_a",  sig_a,  32'h00000003);
        chk("n2_hold_vc_a",   vc_a,   2);

        // single vector, resp=1: one done pulse, signature 1
        num_a = 16'd1; start_a = 1'b1;
        step();
        start_a = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (done_a) done_cnt++;
            step();
        end
        chk("n1_done_pulses_a", done_cnt, 1);
        chk("n1_sig_a",         sig_a,    32'h00000001);
        chk("n1_vc_a",          vc_a,     1);

        // zero vectors: done right after start, no stim_valid, signature cleared
        num_a = 16'd0; start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("n0_done_a", done_a, 1);
        chk("n0_sv_a",   sv_a,   0);
        chk("n0_busy_a", busy_a, 0);
        chk("n0_sig_a",  sig_a,  0);
        step();
        chk("n0_done_off_a", done_a, 0);

        // reset on the third RUN cycle
        seed_a = 32'h0; num_a = 16'd10; start_a = 1'b1;
        step();
        start_a = 1'b0;
        step();
        step();
        chk("pre_rst_vc_a", vc_a, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_stim_a", stim_a, 0);
        chk("mid_rst_sv_a",   sv_a,   0);
        chk("mid_rst_busy_a", busy_a, 0);
        chk("mid_rst_done_a", done_a, 0);
        chk("mid_rst_sig_a",  sig_a,  0);
        chk("mid_rst_vc_a",   vc_a,   0);
        step();
        chk("mid_rst_idle_sv_a", sv_a, 0);

        // fresh start reproduces the uninterrupted sequence
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("re_v0_a", stim_a, 32'h00000001);
        step();
        chk("re_v1_a", stim_a, 32'h80200003);
        step();
        chk("re_v2_a", stim_a, 32'hC0300002);
        step();
        chk("re_v3_a", stim_a, 32'h60180001);
        got_done = 1'b0;
        for (int i = 0; i < 30 && !got_done; i++) begin
            step();
            if (done_a) got_done = 1'b1;
        end
        chk("re_done_seen_a", got_done, 1);
        chk("re_vc_a",        vc_a,     10);

        // reset beats start in the same cycle
        num_a = 16'd5; start_a = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; start_a = 1'b0;
        chk("rst_pri_busy_a", busy_a, 0);
        step();
        chk("rst_pri_sv_a",   sv_a,   0);

        // wide instance, LAT=3, four vectors, resp=0, start pulses while busy
        seed_b = 32'h1; num_b = 16'd4; resp_b = '0; start_b = 1'b1;
        step();
        start_b = 1'b0;
        chk("b_v0_stim", stim_b, 74'h373_9E3779B8_00000001);
        busy_cnt = 0; done_cnt = 0; sv_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (busy_b) busy_cnt++;
            if (done_b) done_cnt++;
            if (sv_b)   sv_cnt++;
            start_b = (i >= 1 && i <= 3);
            step();
        end
        start_b = 1'b0;
        chk("b_busy_cycles", busy_cnt, 7);
        chk("b_done_pulses", done_cnt, 1);
        chk("b_sv_cycles",   sv_cnt,   4);
        chk("b_vc",          vc_b,     4);
        chk("b_sig_zero",    sig_b,    0);

        // multi-chunk fold with zero-extended top chunk: 4 ^ 2 ^ 1 = 7
        resp_b = {23'h1, 32'h2, 32'h4};
        num_b = 16'd1; start_b = 1'b1;
        step();
        start_b = 1'b0;
        step();
        chk("b_drain_stim", stim_b, 0);
        chk("b_drain_busy", busy_b, 1);
        got_done = 1'b0;
        for (int i = 0; i < 10 && !got_done; i++) begin
            step();
            if (done_b) got_done = 1'b1;
        end
        chk("b_fold_done", got_done, 1);
        chk("b_fold_sig",  sig_b,    32'h00000007);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fuzz_vec_harness.md
FUZZ_VEC_HARNESS -- requirements
Module: fuzz_vec_harness

Interface
REQ-001 Parameter IN_W, default 74, total packed stimulus width presented to the DUT.
REQ-002 Parameter OUT_W, default 87, total packed DUT response width.
REQ-003 Parameter LAT, default 1, range 1..8, DUT cycles from stimulus to valid response.
REQ-004 Port clk  in  1  single clock; all state updates on posedge.
REQ-005 Port rst  in  1  synchronous, active-high reset.
REQ-006 Port start  in  1  begin a run; sampled only in IDLE.
REQ-007 Port seed  in  32  LFSR seed, sampled with start.
REQ-008 Port num_vec  in  16  vector count, sampled with start.
REQ-009 Port stim  out  IN_W  packed stimulus to the DUT.
REQ-010 Port stim_valid  out  1  stim holds a live vector this cycle.
REQ-011 Port resp  in  OUT_W  packed DUT response.
REQ-012 Port busy  out  1  high in RUN and DRAIN.
REQ-013 Port done  out  1  one-cycle pulse at run end.
REQ-014 Port signature  out  32  MISR value, held after done.
REQ-015 Port vec_cnt  out  16  vectors issued in the current or last run.

Function
REQ-016 FSM states IDLE, RUN, DRAIN, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-017 IDLE with start=1: LFSR<=seed (32'h1 if seed==0), MISR<=0, vec_cnt<=0, capture num_vec; go RUN, or DONE if num_vec==0.
REQ-018 RUN: stim_valid=1; stim = low IN_W bits of concatenated copies k=0..ceil(IN_W/32)-1 of (lfsr ^ k*32'h9E3779B9), copy 0 in bits [31:0].
REQ-019 Vector n uses the LFSR state after n steps; step = lfsr[0] ? (lfsr>>1)^32'h80200003 : lfsr>>1.
REQ-020 vec_cnt increments once per RUN cycle; RUN exits to DRAIN when vec_cnt reaches captured num_vec.
REQ-021 A LAT-deep valid shift register tracks stim_valid; resp is folded into the MISR exactly when its delayed bit is 1.
REQ-022 Fold = XOR of resp split into 32-bit chunks from bit 0, last chunk zero-extended.
REQ-023 MISR update: sig <= (sig<<1) ^ (sig[31] ? 32'h04C11DB7 : 0) ^ fold.
REQ-024 DRAIN lasts LAT cycles, stim_valid=0, stim=0; then DONE with done=1.
REQ-025 start while busy or in DONE is ignored; no restart, no counter disturbance.
REQ-026 signature and vec_cnt hold their values in IDLE until the next accepted start.
REQ-027 stim=0 whenever stim_valid=0.

Reset
REQ-028 rst=1 at any cycle, including mid-RUN or DRAIN: state IDLE, stim=0, stim_valid=0, busy=0, done=0, signature=0, vec_cnt=0, LFSR=0, valid pipe cleared.
REQ-029 rst has priority over start in the same cycle.

Structure
REQ-030 State encoding, LFSR polynomial, MISR polynomial, mixing constant 32'h9E3779B9 and zero-seed substitute 32'h1 live in a shared package fuzz_harness_pkg.
REQ-031 One sub-module, fuzz_misr (32-bit MISR with OUT_W fold), is instantiated once; the LFSR stays inline.

Verification
REQ-032 IN_W=32, seed=0, num_vec=2: stim = 32'h00000001, then 32'h80200003; vec_cnt ends at 2.
REQ-033 OUT_W=32, LAT=1, num_vec=1, resp held at 32'h1: done pulses once, signature = 32'h00000001.
REQ-034 Same as REQ-033 with num_vec=2: signature = 32'h00000003.
REQ-035 num_vec=0: done one cycle after start, stim_valid never asserts, signature = 0.
REQ-036 rst asserted on the 3rd RUN cycle of num_vec=10: next cycle all outputs are 0; a fresh start produces the same stim sequence as an uninterrupted run.
REQ-037 LAT=3, num_vec=4, resp=0: busy high for exactly 7 cycles, signature = 0; start pulses during busy are ignored.
